// File: rtl/pairwise_pkg.sv
// Shared types and helpers for the pairwise compare engine.
//   state_t     : scan controller states
//   MODE_EQ/NE  : meaning of the in_mode bit
//   cnt_width   : width needed to count up to n*n set bits
//   idx_width   : width of a row index for n channels (at least 1)
package pairwise_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_EQ = 1'b0;
    localparam logic MODE_NE = 1'b1;

    function automatic int cnt_width(input int n);
        return $clog2(n * n + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pairwise_xnor_scan_if.sv
// Handshake bundle for the pairwise compare engine.
//   in_valid/in_ready  : sample handshake, in_data (N*W), in_mode
//   out_valid/out_ready: result handshake, out_matrix (N*N), out_count
// The engine connects through the slave modport; the producer/consumer
// side uses master.
interface pairwise_xnor_scan_if
    import pairwise_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 1
);
    localparam int CNT_W = cnt_width(N);

    logic                 in_valid;
    logic                 in_ready;
    logic [N*W-1:0]       in_data;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [N*N-1:0]       out_matrix;
    logic [CNT_W-1:0]     out_count;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_matrix, out_count
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_matrix, out_count
    );

endinterface

// File: rtl/pairwise_row_cmp.sv
// Combinational row comparator: compares channel `row` of the captured
// sample against every channel j and returns one match bit per j.
//   data      : N channels of W bits, channel 0 in the MSBs
//   row       : index of the channel being compared
//   mode      : MODE_EQ -> match when equal, MODE_NE -> match when different
//   row_bits  : match(row, j), j=0 in the MSB
//   row_count : number of set bits in row_bits
module pairwise_row_cmp
    import pairwise_pkg::*;
#(
    parameter  int N   = 5,
    parameter  int W   = 1,
    localparam int RW  = idx_width(N),
    localparam int PCW = $clog2(N + 1)
) (
    input  logic [N*W-1:0] data,
    input  logic [RW-1:0]  row,
    input  logic           mode,
    output logic [N-1:0]   row_bits,
    output logic [PCW-1:0] row_count
);

    logic [W-1:0] chans [N];
    logic [W-1:0] sel;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign chans[gi] = data[(N-1-gi)*W +: W];
        end
    endgenerate

    // The row index never exceeds N-1 while scanning.
    assign sel = chans[row];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cmp
            logic eq;
            assign eq = &(~(sel ^ chans[gi]));
            assign row_bits[N-1-gi] = (mode == MODE_NE) ? ~eq : eq;
        end
    endgenerate

    always_comb begin
        row_count = '0;
        for (int k = 0; k < N; k++) begin
            row_count = row_count + PCW'(row_bits[k]);
        end
    end

endmodule

// File: rtl/pairwise_xnor_scan.sv
// Sequential NxN pairwise compare engine. Captures one N-channel sample,
// scans one matrix row per clock, then holds the full match matrix and
// its popcount until the consumer takes it.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset; aborts any scan in progress
//   bus   : slave side of pairwise_xnor_scan_if (sample in, result out)
module pairwise_xnor_scan
    import pairwise_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pairwise_xnor_scan_if.slave  bus
);

    localparam int CNT_W = cnt_width(N);
    localparam int RW    = idx_width(N);
    localparam int PCW   = $clog2(N + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    state_t           state_reg, state_next;
    logic [N*W-1:0]   data_reg, data_next;
    logic             mode_reg, mode_next;
    logic [RW-1:0]    row_reg, row_next;
    logic [N*N-1:0]   matrix_reg, matrix_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic [N-1:0]     row_bits;
    logic [PCW-1:0]   row_count;

    pairwise_row_cmp #(
        .N (N),
        .W (W)
    ) u_row_cmp (
        .data      (data_reg),
        .row       (row_reg),
        .mode      (mode_reg),
        .row_bits  (row_bits),
        .row_count (row_count)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.in_valid)          state_next = SCAN;
            SCAN:    if (row_reg == LAST_ROW)   state_next = DONE;
            DONE:    if (bus.out_ready)         state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Output logic: result is only visible once the whole matrix is built,
    // so a reset or a scan in progress never exposes a partial result.
    always_comb begin
        bus.in_ready   = (state_reg == IDLE);
        bus.out_valid  = (state_reg == DONE);
        bus.out_matrix = matrix_reg;
        bus.out_count  = count_reg;
    end

    // Datapath next values
    always_comb begin
        data_next   = data_reg;
        mode_next   = mode_reg;
        row_next    = row_reg;
        matrix_next = matrix_reg;
        count_next  = count_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    data_next   = bus.in_data;
                    mode_next   = bus.in_mode;
                    row_next    = '0;
                    matrix_next = '0;
                    count_next  = '0;
                end
            end
            SCAN: begin
                // Row i occupies bits [N*N-1-i*N -: N] of the matrix.
                for (int i = 0; i < N; i++) begin
                    if (row_reg == RW'(i)) begin
                        matrix_next[N*N-1-i*N -: N] = row_bits;
                    end
                end
                count_next = count_reg + CNT_W'(row_count);
                if (row_reg != LAST_ROW) begin
                    row_next = row_reg + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg   <= '0;
            mode_reg   <= MODE_EQ;
            row_reg    <= '0;
            matrix_reg <= '0;
            count_reg  <= '0;
        end else begin
            data_reg   <= data_next;
            mode_reg   <= mode_next;
            row_reg    <= row_next;
            matrix_reg <= matrix_next;
            count_reg  <= count_next;
        end
    end

endmodule
